// File: rtl/debug_rom_ctrl_if.sv
// debug_rom_ctrl_if
//   Groups the debug-module control/status signals and the core fetch port of
//   debug_rom_ctrl. The _i/_o suffixes are from the controller's point of view.
//   Modports:
//     slave  - the controller (debug_rom_ctrl)
//     master - the debug module and core side that drive requests
//   Signals:
//     dm_haltreq_i, dm_resumereq_i, dm_go_i : halt/resume level, go pulse
//     dm_pb_we_i, dm_pb_addr_i, dm_pb_wdata_i : program-buffer write port
//     dm_clrerr_i                            : clears the sticky cmderr
//     dm_halted_o, dm_busy_o, dm_cmderr_o    : status
//     debug_strobe_o                         : debug-entry pulse to the core
//     mem_req_i, mem_addr_i                  : core fetch request (0xCDxx_xxxx window)
//     mem_rdata_o, mem_ready_o               : fetch response, one cycle later
interface debug_rom_ctrl_if #(
  parameter int XLEN     = 32,
  parameter int PB_WORDS = 8
);
  localparam int AW = $clog2(PB_WORDS);

  logic            dm_haltreq_i;
  logic            dm_resumereq_i;
  logic            dm_go_i;
  logic            dm_pb_we_i;
  logic [AW-1:0]   dm_pb_addr_i;
  logic [XLEN-1:0] dm_pb_wdata_i;
  logic            dm_clrerr_i;
  logic            dm_halted_o;
  logic            dm_busy_o;
  logic            dm_cmderr_o;
  logic            debug_strobe_o;
  logic            mem_req_i;
  logic [XLEN-1:0] mem_addr_i;
  logic [XLEN-1:0] mem_rdata_o;
  logic            mem_ready_o;

  modport slave (
    input  dm_haltreq_i, dm_resumereq_i, dm_go_i,
    input  dm_pb_we_i, dm_pb_addr_i, dm_pb_wdata_i, dm_clrerr_i,
    output dm_halted_o, dm_busy_o, dm_cmderr_o, debug_strobe_o,
    input  mem_req_i, mem_addr_i,
    output mem_rdata_o, mem_ready_o
  );

  modport master (
    output dm_haltreq_i, dm_resumereq_i, dm_go_i,
    output dm_pb_we_i, dm_pb_addr_i, dm_pb_wdata_i, dm_clrerr_i,
    input  dm_halted_o, dm_busy_o, dm_cmderr_o, debug_strobe_o,
    output mem_req_i, mem_addr_i,
    input  mem_rdata_o, mem_ready_o
  );
endinterface

// File: rtl/debug_rom_ctrl.sv
// debug_rom_ctrl
//   Debug ROM controller: tracks the hart's debug state and serves the debug
//   ROM window (park loop, program buffer, return jump) to the core fetch port
//   with a fixed one-cycle pipelined response.
//   Ports:
//     clk_i  - sole clock
//     rst_i  - synchronous, active-high reset
//     bus    - debug_rom_ctrl_if.slave (debug-module control/status + fetch port)
//   Build option:
//     DEBUG_PROGBUF_EN - when defined, the program buffer, go/EXEC path and the
//                        return jump exist; otherwise PB/RET offsets read as
//                        the park loop and every go is a command error.
module debug_rom_ctrl #(
  parameter int XLEN     = 32,
  parameter int PB_WORDS = 8
) (
  input logic             clk_i,
  input logic             rst_i,
  debug_rom_ctrl_if.slave bus
);
  localparam int          AW        = $clog2(PB_WORDS);
  localparam logic [11:0] PB_BASE   = 12'h100;
  localparam logic [11:0] RET_OFF   = 12'(256 + 4 * PB_WORDS);
  localparam int          RET_DIST  = 256 + 4 * PB_WORDS;
  localparam logic [31:0] INSN_LOOP = 32'h0000_006F;
  localparam logic [31:0] INSN_GO   = 32'h1000_006F;
  localparam logic [31:0] INSN_DRET = 32'h7B20_0073;
  localparam logic [31:0] INSN_NOP  = 32'h0000_0013;

  // jal x0, off
  function automatic logic [31:0] jal_x0(input logic signed [20:0] off);
    return {off[20], off[10:1], off[11], off[19:12], 5'd0, 7'h6F};
  endfunction

  localparam logic signed [20:0] RET_JUMP = 21'(-RET_DIST);
  localparam logic [31:0]        INSN_RET = jal_x0(RET_JUMP);

  typedef enum logic [2:0] {
    RUNNING, HALT_WAIT, HALTED, EXEC, EXEC_RUN, RESUMING
  } state_e;

  state_e          state_p0, state_nxt;
  logic            dret_served_p0;
  logic [11:0]     off;
  logic            fetch_park, fetch_hi;
  logic            go_ok, go_err, wr_err;
  logic [XLEN-1:0] pb_rd, rdata_d;
  logic            halted, busy;
  logic            strobe_p1, cmderr_p1, vld_p1;
  logic [XLEN-1:0] rdata_p1;

  assign off        = bus.mem_addr_i[11:0];
  assign fetch_park = bus.mem_req_i && (off == 12'h000);
  assign fetch_hi   = bus.mem_req_i && (off >= PB_BASE);

`ifdef DEBUG_PROGBUF_EN
  logic [AW-1:0]   pb_idx;
  logic            pb_wr_ok;
  logic [XLEN-1:0] pb_mem [PB_WORDS];
  logic            unused_addr;

  assign pb_idx   = AW'((off - PB_BASE) >> 2);
  assign pb_wr_ok = bus.dm_pb_we_i && (state_p0 == HALTED || state_p0 == RUNNING);
  assign wr_err   = bus.dm_pb_we_i && !pb_wr_ok;
  assign go_ok    = bus.dm_go_i && (state_p0 == HALTED);
  assign go_err   = bus.dm_go_i && (state_p0 != HALTED);
  assign unused_addr = ^bus.mem_addr_i[XLEN-1:12];

  always_comb begin
    pb_rd = XLEN'(INSN_LOOP);
    if (off >= PB_BASE && off < RET_OFF) pb_rd = pb_mem[pb_idx];
    else if (off == RET_OFF)              pb_rd = XLEN'(INSN_RET);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < PB_WORDS; i++) pb_mem[i] <= XLEN'(INSN_NOP);
    end else if (pb_wr_ok) begin
      pb_mem[bus.dm_pb_addr_i] <= bus.dm_pb_wdata_i;
    end
  end
`else
  logic unused_pb;

  assign wr_err    = 1'b0;
  assign go_ok     = 1'b0;
  assign go_err    = bus.dm_go_i;
  assign pb_rd     = XLEN'(INSN_LOOP);
  assign unused_pb = ^{bus.dm_pb_we_i, bus.dm_pb_addr_i, bus.dm_pb_wdata_i,
                       bus.mem_addr_i[XLEN-1:12]};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_p0 <= RUNNING;
    else       state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      RUNNING:   if (bus.dm_haltreq_i) state_nxt = HALT_WAIT;
      HALT_WAIT: if (fetch_park) state_nxt = HALTED;
      // Resume has priority over a same-cycle go.
      HALTED: begin
        if (bus.dm_resumereq_i) state_nxt = RESUMING;
        else if (go_ok)         state_nxt = EXEC;
      end
      EXEC:      if (fetch_hi) state_nxt = EXEC_RUN;
      EXEC_RUN:  if (fetch_park) state_nxt = HALTED;
      // Leave only once dret has been handed out and the core stops fetching.
      RESUMING:  if (dret_served_p0 && !bus.mem_req_i) state_nxt = RUNNING;
      default:   state_nxt = RUNNING;
    endcase
  end

  always_comb begin
    halted = 1'b0;
    busy   = 1'b0;
    case (state_p0)
      HALTED:              halted = 1'b1;
      EXEC, EXEC_RUN:      begin halted = 1'b1; busy = 1'b1; end
      HALT_WAIT, RESUMING: busy = 1'b1;
      default: ;
    endcase
  end

  // Park word depends on the state at the time of the fetch.
  always_comb begin
    rdata_d = pb_rd;
    if (off == 12'h000) begin
      case (state_p0)
        EXEC:     rdata_d = XLEN'(INSN_GO);
        RESUMING: rdata_d = XLEN'(INSN_DRET);
        default:  rdata_d = XLEN'(INSN_LOOP);
      endcase
    end
  end

  // ---- stage p0 -> p1: fetch response, strobe and error status ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dret_served_p0 <= 1'b0;
      strobe_p1      <= 1'b0;
      cmderr_p1      <= 1'b0;
      vld_p1         <= 1'b0;
      rdata_p1       <= '0;
    end else begin
      dret_served_p0 <= (state_nxt == RESUMING) &&
                        (dret_served_p0 || (state_p0 == RESUMING && fetch_park));
      strobe_p1      <= (state_p0 == RUNNING) && bus.dm_haltreq_i;
      cmderr_p1      <= (go_err || wr_err) ? 1'b1 :
                        (bus.dm_clrerr_i ? 1'b0 : cmderr_p1);
      vld_p1         <= bus.mem_req_i;
      if (bus.mem_req_i) rdata_p1 <= rdata_d;
    end
  end

  assign bus.dm_halted_o    = halted;
  assign bus.dm_busy_o      = busy;
  assign bus.dm_cmderr_o    = cmderr_p1;
  assign bus.debug_strobe_o = strobe_p1;
  assign bus.mem_ready_o    = vld_p1;
  assign bus.mem_rdata_o    = rdata_p1;
endmodule

// File: tb/tb_debug_rom_ctrl.sv
// tb_debug_rom_ctrl
//   Directed vector table, hand-written corner sequences and a randomized run
//   against a behavioural model of debug_rom_ctrl. Works with and without
//   DEBUG_PROGBUF_EN defined.
module tb_debug_rom_ctrl;
  localparam int XLEN     = 32;
  localparam int PB_WORDS = 8;
`ifdef DEBUG_PROGBUF_EN
  localparam logic P = 1'b1;
`else
  localparam logic P = 1'b0;
`endif
  localparam logic [31:0] LOOP = 32'h0000_006F;
  localparam logic [31:0] GO   = 32'h1000_006F;
  localparam logic [31:0] DRET = 32'h7B20_0073;
  localparam logic [31:0] RET  = 32'hEE1F_F06F;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0015_0513;

  localparam int M_RUN = 0, M_HWAIT = 1, M_HALTED = 2, M_EXEC = 3, M_EXRUN = 4, M_RESUME = 5;

  typedef struct packed {
    logic        rst, halt, res, go, we;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic        clr, req;
    logic [31:0] addr;
    logic        halted, busy, strobe, err, ready;
    logic [31:0] rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  debug_rom_ctrl_if #(.XLEN(XLEN), .PB_WORDS(PB_WORDS)) bus ();

  debug_rom_ctrl #(.XLEN(XLEN), .PB_WORDS(PB_WORDS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model state
  int          m_mode;
  logic        m_dret, m_err, m_strobe, m_ready;
  logic [31:0] m_rdata;
  logic [31:0] m_pb [PB_WORDS];

  function automatic vec_t row(input logic rst_v, halt, res, go, we, input logic [2:0] wa,
                               input logic [31:0] wd, input logic clr, req, input logic [11:0] off,
                               input logic h, b, st, er, rdy, input logic [31:0] rd);
    vec_t v;
    v.rst = rst_v; v.halt = halt; v.res = res; v.go = go; v.we = we; v.wa = wa; v.wd = wd;
    v.clr = clr; v.req = req; v.addr = {20'hCD000, off};
    v.halted = h; v.busy = b; v.strobe = st; v.err = er; v.ready = rdy; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic drive(input vec_t v);
    rst                = v.rst;
    bus.dm_haltreq_i   = v.halt;
    bus.dm_resumereq_i = v.res;
    bus.dm_go_i        = v.go;
    bus.dm_pb_we_i     = v.we;
    bus.dm_pb_addr_i   = v.wa;
    bus.dm_pb_wdata_i  = v.wd;
    bus.dm_clrerr_i    = v.clr;
    bus.mem_req_i      = v.req;
    bus.mem_addr_i     = v.addr;
  endtask

  function automatic logic [31:0] status();
    return 32'({bus.dm_halted_o, bus.dm_busy_o, bus.debug_strobe_o, bus.dm_cmderr_o, bus.mem_ready_o});
  endfunction

  task automatic run(input vec_t v, input string nm);
    drive(v);
    @(posedge clk); #1;
    chk({nm, ".status{halted,busy,strobe,err,ready}"}, status(),
        32'({v.halted, v.busy, v.strobe, v.err, v.ready}));
    if (v.ready || v.rst) chk({nm, ".rdata"}, bus.mem_rdata_o, v.rd);
  endtask

  task automatic model_reset();
    m_mode = M_RUN; m_dret = 1'b0; m_err = 1'b0; m_strobe = 1'b0;
    m_ready = 1'b0; m_rdata = '0;
    for (int i = 0; i < PB_WORDS; i++) m_pb[i] = NOP;
  endtask

  function automatic logic [31:0] model_fetch(input int o);
    if (o == 0) return (m_mode == M_EXEC) ? GO : (m_mode == M_RESUME) ? DRET : LOOP;
    if (P && o >= 256 && o < 256 + 4 * PB_WORDS) return m_pb[(o - 256) / 4];
    if (P && o == 256 + 4 * PB_WORDS) return RET;
    return LOOP;
  endfunction

  task automatic model_edge(input vec_t s);
    int   o, nm;
    logic e;
    if (s.rst) begin
      model_reset();
      return;
    end
    o  = int'(s.addr[11:0]);
    nm = m_mode;
    m_ready = s.req;
    if (s.req) m_rdata = model_fetch(o);
    m_strobe = (m_mode == M_RUN) && s.halt;
    e = (s.go && !(P && m_mode == M_HALTED));
    if (s.we) begin
      if (m_mode == M_HALTED || m_mode == M_RUN) begin
        if (P) m_pb[s.wa] = s.wd;
      end else if (P) e = 1'b1;
    end
    m_err = e ? 1'b1 : (s.clr ? 1'b0 : m_err);
    case (m_mode)
      M_RUN:    if (s.halt) nm = M_HWAIT;
      M_HWAIT:  if (s.req && o == 0) nm = M_HALTED;
      M_HALTED: if (s.res) nm = M_RESUME; else if (s.go && P) nm = M_EXEC;
      M_EXEC:   if (s.req && o >= 256) nm = M_EXRUN;
      M_EXRUN:  if (s.req && o == 0) nm = M_HALTED;
      M_RESUME: if (m_dret && !s.req) nm = M_RUN; else if (s.req && o == 0) m_dret = 1'b1;
      default: ;
    endcase
    if (nm == M_RESUME && m_mode != M_RESUME) m_dret = 1'b0;
    m_mode = nm;
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    //               rst h r g w wa wd            c q off      | hl bs st  er  rdy rd
    tbl.push_back(row(1,0,0,0,0,0,32'h0,        0,0,12'h000,   0, 0, 0,  0,  0, 32'h0));
    tbl.push_back(row(0,1,0,0,0,0,32'h0,        0,0,12'h000,   0, 1, 1,  0,  0, 32'h0));
    tbl.push_back(row(0,1,0,0,0,0,32'h0,        0,0,12'h000,   0, 1, 0,  0,  0, 32'h0));
    tbl.push_back(row(0,0,0,0,0,0,32'h0,        0,1,12'h000,   1, 0, 0,  0,  1, LOOP));
    tbl.push_back(row(0,0,0,0,0,0,32'h0,        0,0,12'h000,   1, 0, 0,  0,  0, 32'h0));
    tbl.push_back(row(0,0,0,0,1,0,ADDI,         0,0,12'h000,   1, 0, 0,  0,  0, 32'h0));
    tbl.push_back(row(0,0,0,1,0,0,32'h0,        0,0,12'h000,   1, P, 0, ~P,  0, 32'h0));
    tbl.push_back(row(0,0,0,0,0,0,32'h0,        0,1,12'h000,   1, P, 0, ~P,  1, P ? GO : LOOP));
    tbl.push_back(row(0,0,0,0,0,0,32'h0,        0,1,12'h100,   1, P, 0, ~P,  1, P ? ADDI : LOOP));
    tbl.push_back(row(0,0,0,0,0,0,32'h0,        0,1,12'h120,   1, P, 0, ~P,  1, P ? RET : LOOP));
    tbl.push_back(row(0,0,0,0,1,0,32'hDEADBEEF, 0,0,12'h000,   1, P, 0,  1,  0, 32'h0));
    tbl.push_back(row(0,0,0,0,0,0,32'h0,        0,1,12'h100,   1, P, 0,  1,  1, P ? ADDI : LOOP));
    tbl.push_back(row(0,0,0,0,0,0,32'h0,        1,0,12'h000,   1, P, 0,  0,  0, 32'h0));
    tbl.push_back(row(0,0,0,0,0,0,32'h0,        0,1,12'h000,   1, 0, 0,  0,  1, LOOP));
    tbl.push_back(row(0,0,1,1,0,0,32'h0,        0,0,12'h000,   0, 1, 0, ~P,  0, 32'h0));
    tbl.push_back(row(0,0,0,0,0,0,32'h0,        0,1,12'h000,   0, 1, 0, ~P,  1, DRET));
    tbl.push_back(row(0,0,0,0,0,0,32'h0,        0,0,12'h000,   0, 0, 0, ~P,  0, 32'h0));
    tbl.push_back(row(0,0,0,0,0,0,32'h0,        1,0,12'h000,   0, 0, 0,  0,  0, 32'h0));
    tbl.push_back(row(0,0,0,1,0,0,32'h0,        0,0,12'h000,   0, 0, 0,  1,  0, 32'h0));
    tbl.push_back(row(0,0,1,0,0,0,32'h0,        0,0,12'h000,   0, 0, 0,  1,  0, 32'h0));
    tbl.push_back(row(0,0,0,0,0,0,32'h0,        1,0,12'h000,   0, 0, 0,  0,  0, 32'h0));
    tbl.push_back(row(0,1,0,0,0,0,32'h0,        0,0,12'h000,   0, 1, 1,  0,  0, 32'h0));
    tbl.push_back(row(0,0,0,0,0,0,32'h0,        0,1,12'h000,   1, 0, 0,  0,  1, LOOP));
    tbl.push_back(row(0,0,0,1,0,0,32'h0,        0,0,12'h000,   1, P, 0, ~P,  0, 32'h0));
    tbl.push_back(row(0,0,0,0,0,0,32'h0,        0,1,12'h104,   1, P, 0, ~P,  1, P ? NOP : LOOP));
    tbl.push_back(row(1,0,0,0,0,0,32'h0,        0,1,12'h000,   0, 0, 0,  0,  0, 32'h0));
    tbl.push_back(row(0,1,0,0,0,0,32'h0,        0,0,12'h000,   0, 1, 1,  0,  0, 32'h0));
    tbl.push_back(row(0,0,0,0,0,0,32'h0,        0,1,12'h000,   1, 0, 0,  0,  1, LOOP));
    tbl.push_back(row(0,0,0,0,0,0,32'h0,        0,1,12'h100,   1, 0, 0,  0,  1, P ? NOP : LOOP));

    drive(row(1,0,0,0,0,0,32'h0,0,0,12'h000, 0,0,0,0,0,32'h0));
    for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("row%0d", i));

    // Multi-cycle corner sequences
    run(row(1,0,0,0,0,0,32'h0,        0,0,12'h000, 0,0,0,0, 0,32'h0), "seq_reset");
    run(row(0,0,0,1,0,0,32'h0,        1,0,12'h000, 0,0,0,1, 0,32'h0), "seq_set_beats_clear");
    run(row(0,1,0,0,0,0,32'h0,        1,0,12'h000, 0,1,1,0, 0,32'h0), "seq_halt");
    run(row(0,0,0,0,0,0,32'h0,        0,1,12'h100, 0,1,0,0, 1,P ? NOP : LOOP), "seq_haltwait_nonpark");
    run(row(0,0,0,0,1,0,32'hBAD0BAD0, 0,0,12'h000, 0,1,0,P, 0,32'h0), "seq_write_in_haltwait");
    run(row(0,0,0,0,0,0,32'h0,        1,1,12'h000, 1,0,0,0, 1,LOOP), "seq_park_halts");
    run(row(0,1,0,0,0,0,32'h0,        0,0,12'h000, 1,0,0,0, 0,32'h0), "seq_haltreq_ignored");
    run(row(0,0,1,0,0,0,32'h0,        0,0,12'h000, 0,1,0,0, 0,32'h0), "seq_resume");
    run(row(0,0,0,0,0,0,32'h0,        0,0,12'h000, 0,1,0,0, 0,32'h0), "seq_idle_before_dret");
    run(row(0,0,0,0,0,0,32'h0,        0,1,12'h000, 0,1,0,0, 1,DRET), "seq_dret1");
    run(row(0,0,0,0,0,0,32'h0,        0,1,12'h000, 0,1,0,0, 1,DRET), "seq_dret2");
    run(row(0,0,0,0,0,0,32'h0,        0,0,12'h000, 0,0,0,0, 0,32'h0), "seq_running");
    run(row(0,1,0,0,0,0,32'h0,        0,0,12'h000, 0,1,1,0, 0,32'h0), "seq_rehalt");
    run(row(0,0,0,0,0,0,32'h0,        0,1,12'h000, 1,0,0,0, 1,LOOP), "seq_rehalt_park");
    run(row(0,0,0,0,0,0,32'h0,        0,1,12'h100, 1,0,0,0, 1,P ? NOP : LOOP), "seq_dropped_write");

    // Randomized run against the model
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      int          sel;
      logic [11:0] o;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0, 1, 2: o = 12'h000;
        3:       o = 12'(256 + 4 * $urandom_range(0, PB_WORDS - 1));
        4:       o = 12'(256 + 4 * PB_WORDS);
        default: o = 12'($urandom_range(0, 1023) * 4);
      endcase
      v = row((c == 0) || ($urandom_range(0, 199) == 0),
              $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
              3'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, o,
              0, 0, 0, 0, 0, 32'h0);
      drive(v);
      @(posedge clk); #1;
      model_edge(v);
      chk($sformatf("rand%0d.status{halted,busy,strobe,err,ready}", c), status(),
          32'({(m_mode == M_HALTED || m_mode == M_EXEC || m_mode == M_EXRUN),
               (m_mode == M_HWAIT || m_mode == M_EXEC || m_mode == M_EXRUN || m_mode == M_RESUME),
               m_strobe, m_err, m_ready}));
      if (m_ready || v.rst) chk($sformatf("rand%0d.rdata", c), bus.mem_rdata_o, m_rdata);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/debug_rom_ctrl.md
DEBUG_ROM_CTRL -- requirements
Module: debug_rom_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, instruction/address width.
REQ-002 SHALL have parameter PB_WORDS, default 8, program-buffer depth in words (power of two, 2..16).
REQ-003 SHALL have port clk_i, input, 1, sole clock.
REQ-004 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port dm_haltreq_i, input, 1, debugger halt request (level).
REQ-006 SHALL have port dm_resumereq_i, input, 1, resume request (level).
REQ-007 SHALL have port dm_go_i, input, 1, single-cycle pulse to execute the program buffer.
REQ-008 SHALL have ports dm_pb_we_i (input, 1), dm_pb_addr_i (input, $clog2(PB_WORDS)) and dm_pb_wdata_i (input, XLEN), forming the program-buffer write port.
REQ-009 SHALL have port dm_clrerr_i, input, 1, clears cmderr.
REQ-010 SHALL have outputs dm_halted_o, dm_busy_o and dm_cmderr_o, each 1 bit, giving status.
REQ-011 SHALL have port debug_strobe_o, output, 1, debug-entry pulse to the core.
REQ-012 SHALL have ports mem_req_i (input, 1) and mem_addr_i (input, XLEN), the core fetch request level for the 0xCDxx_xxxx window and its address.
REQ-013 SHALL have ports mem_rdata_o (output, XLEN) and mem_ready_o (output, 1), the fetch response.

Function
REQ-014 SHALL make the fetch path pipelined: every cycle with mem_req_i=1 SHALL produce mem_ready_o=1 next cycle, with mem_rdata_o registered from that cycle's address.
REQ-015 SHALL decode word offset = mem_addr_i[11:0]; 0x000 is PARK; 0x100..0x100+4*PB_WORDS-4 is PB[i]; 0x100+4*PB_WORDS is RET; all others return 0x0000006F.
REQ-016 SHALL return at PARK, by state: HALTED/HALT_WAIT -> 0x0000006F (jal x0,0); EXEC -> 0x1000006F (jal to 0x100); RESUMING -> 0x7B200073 (dret); EXEC_RUN -> 0x0000006F.
REQ-017 SHALL return at RET 0xEE1FF06F (jal back to 0x000) when PB_WORDS=8; for other depths it SHALL return the JAL encoding of -(0x100+4*PB_WORDS).
REQ-018 SHALL use states RUNNING, HALT_WAIT, HALTED, EXEC, EXEC_RUN, RESUMING.
REQ-019 RUNNING: when dm_haltreq_i=1, debug_strobe_o SHALL be 1 for exactly one cycle and the state SHALL go to HALT_WAIT.
REQ-020 HALT_WAIT: a fetch of PARK SHALL move the state to HALTED; dm_halted_o=1 the cycle after.
REQ-021 HALTED: dm_resumereq_i SHALL move the state to RESUMING; otherwise dm_go_i SHALL move it to EXEC; resume SHALL win if both are present in the same cycle.
REQ-022 EXEC: the first fetch at offset >= 0x100 SHALL move the state to EXEC_RUN; EXEC_RUN: a fetch of PARK SHALL move it to HALTED.
REQ-023 RESUMING: after dret has been served at PARK, the first cycle with mem_req_i=0 SHALL move the state to RUNNING.
REQ-024 dm_halted_o SHALL be 1 in HALTED/EXEC/EXEC_RUN; dm_busy_o SHALL be 1 in EXEC/EXEC_RUN/HALT_WAIT/RESUMING.
REQ-025 PB writes SHALL take effect the next cycle only in HALTED or RUNNING; a write in any other state SHALL be dropped and SHALL set dm_cmderr_o.
REQ-026 dm_go_i outside HALTED SHALL be ignored and SHALL set dm_cmderr_o; dm_cmderr_o SHALL be sticky until dm_clrerr_i (set wins over a same-cycle clear).
REQ-027 dm_haltreq_i outside RUNNING and dm_resumereq_i outside HALTED SHALL be ignored without error.

Reset
REQ-028 On rst_i the state SHALL be RUNNING; every output SHALL be 0; all PB words SHALL be 0x00000013 (nop); any in-flight response SHALL be discarded, including mid-EXEC.

Configuration
REQ-029 SHALL gate the program buffer with macro DEBUG_PROGBUF_EN. With the macro defined: REQ-015..026 apply. Without it: no PB storage; PB/RET offsets return 0x0000006F; dm_go_i always sets dm_cmderr_o; EXEC/EXEC_RUN are unreachable; PB writes are ignored without error.

Verification
REQ-030 Reset, then haltreq=1 -> debug_strobe_o pulses one cycle; fetch 0xCD000000 -> rdata 0x0000006F, ready next cycle, dm_halted_o=1.
REQ-031 Halted, write PB[0]=0x00150513, go -> PARK fetch returns 0x1000006F; 0xCD000100 returns 0x00150513; 0xCD000120 returns 0xEE1FF06F; PARK fetch -> HALTED, busy=0.
REQ-032 Halted, resumereq and go in the same cycle -> PARK returns 0x7B200073; mem_req_i drops -> dm_halted_o=0, cmderr=0.
REQ-033 PB write during EXEC_RUN -> PB unchanged, cmderr=1; clrerr -> cmderr=0.
REQ-034 rst_i asserted in EXEC_RUN -> next cycle RUNNING, outputs 0, PB[0] reads 0x00000013 after re-halt.
REQ-035 Macro undefined: go in HALTED -> cmderr=1, state stays HALTED, 0xCD000100 returns 0x0000006F.
